// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / multi-cycle EX / MEM wait sequencing,
// jump flush generation and stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [4:0]       id_Rs1,
   input  logic [4:0]       id_Rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_Rd,
   input  logic             ex_busy_req,
   input  logic             ex_done,
   input  logic             mem_req,
   input  logic             mem_ack,
   input  logic             ex_jump_en,
   input  logic [31:0]      ex_jump_addr,
   output logic [2:0]       flag_hold,
   output logic             flag_flush,
   output logic             jump_en_o,
   output logic [31:0]      jump_addr_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {IDLE, EX_BUSY, MEM_WAIT} state_t;

   localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

   state_t           state, state_nxt;
   logic             ex_pend, ex_pend_nxt;
   logic             done_seen, done_seen_nxt;
   logic [15:0]      tmo_cnt, tmo_nxt;
   logic [CNT_W-1:0] stall_q, flush_q;

   logic       mem_wait_cond, mem_stall, mem_tmo, ex_hold, load_use, flush;
   logic [2:0] hold;

   always_comb begin
      mem_wait_cond = mem_req & ~mem_ack;
      mem_stall     = mem_wait_cond & (tmo_cnt != TMO_LAST);
      mem_tmo       = mem_wait_cond & (tmo_cnt == TMO_LAST);
      // A done seen during a MEM stall already released the EX op.
      ex_hold       = ex_busy_req | (ex_pend & ~ex_done & ~done_seen);
      load_use      = ex_mem_read & (ex_Rd != 5'd0) &
                      ((id_rs1_used & (id_Rs1 == ex_Rd)) |
                       (id_rs2_used & (id_Rs2 == ex_Rd)));
      flush         = ex_jump_en & ~mem_stall & ~ex_hold;

      hold = 3'b000;
      if (mem_stall)             hold = 3'b100;
      else if (ex_hold)          hold = 3'b010;
      else if (load_use & ~flush) hold = 3'b001;
   end

   always_comb begin
      ex_pend_nxt   = ex_pend;
      done_seen_nxt = done_seen;
      if (ex_busy_req) begin
         ex_pend_nxt   = 1'b1;
         done_seen_nxt = 1'b0;
      end else if (ex_pend) begin
         if (mem_stall) begin
            if (ex_done) done_seen_nxt = 1'b1;
         end else if (ex_done | done_seen) begin
            ex_pend_nxt   = 1'b0;
            done_seen_nxt = 1'b0;
         end
      end

      tmo_nxt = '0;
      if (mem_stall) tmo_nxt = (state == MEM_WAIT) ? tmo_cnt + 16'd1 : 16'd1;

      if (mem_stall)        state_nxt = MEM_WAIT;
      else if (ex_pend_nxt) state_nxt = EX_BUSY;
      else                  state_nxt = IDLE;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         ex_pend   <= 1'b0;
         done_seen <= 1'b0;
         tmo_cnt   <= '0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state     <= state_nxt;
         ex_pend   <= ex_pend_nxt;
         done_seen <= done_seen_nxt;
         tmo_cnt   <= tmo_nxt;
         if (hold != 3'b000) stall_q <= stall_q + 1'b1;
         if (flush)          flush_q <= flush_q + 1'b1;
      end
   end

   always_comb begin
      flag_hold     = sys_rst ? 3'b000 : hold;
      flag_flush    = ~sys_rst & flush;
      jump_en_o     = ~sys_rst & flush;
      jump_addr_o   = (~sys_rst & flush) ? ex_jump_addr : '0;
      mem_timeout_o = ~sys_rst & mem_tmo;
      stall_cnt     = sys_rst ? '0 : stall_q;
      flush_cnt     = sys_rst ? '0 : flush_q;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic
// against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
   localparam int CW  = 8;
   localparam int TMO = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          sys_rst;
   logic [4:0]    id_Rs1, id_Rs2, ex_Rd;
   logic          id_rs1_used, id_rs2_used, ex_mem_read;
   logic          ex_busy_req, ex_done, mem_req, mem_ack, ex_jump_en;
   logic [31:0]   ex_jump_addr;
   logic [2:0]    flag_hold;
   logic          flag_flush, jump_en_o, mem_timeout_o;
   logic [31:0]   jump_addr_o;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
      .sys_clk(clk), .sys_rst(sys_rst),
      .id_Rs1(id_Rs1), .id_Rs2(id_Rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_mem_read(ex_mem_read), .ex_Rd(ex_Rd),
      .ex_busy_req(ex_busy_req), .ex_done(ex_done),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .ex_jump_en(ex_jump_en), .ex_jump_addr(ex_jump_addr),
      .flag_hold(flag_hold), .flag_flush(flag_flush),
      .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
      .mem_timeout_o(mem_timeout_o),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic [2:0]  hold;
      logic        flush;
      logic [31:0] jaddr;
      logic        tmo;
      int          sc;
      int          fc;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int errors = 0;

   // Model state: an outstanding multi-cycle op, whether its result already
   // arrived while MEM was stalled, MEM wait cycles so far, and event counts.
   bit m_pending, m_result_early;
   int m_waited, m_stalls, m_flushes;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("flag_hold", 32'(flag_hold), 32'(e.hold));
         chk("flag_flush", 32'(flag_flush), 32'(e.flush));
         chk("jump_en_o", 32'(jump_en_o), 32'(e.flush));
         chk("jump_addr_o", jump_addr_o, e.jaddr);
         chk("mem_timeout_o", 32'(mem_timeout_o), 32'(e.tmo));
         chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
         chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
   end

   // Predict this cycle's outputs from the current inputs, queue them, then
   // advance the model as the clock edge does.
   task automatic step();
      exp_t e;
      bit mem_blocked, mem_stalls, ex_holds, hazard, redirect;
      e = '{hold: 3'b000, flush: 1'b0, jaddr: 32'h0, tmo: 1'b0, sc: 0, fc: 0};
      if (sys_rst) begin
         m_pending = 0; m_result_early = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
      end else begin
         mem_blocked = mem_req && !mem_ack;
         mem_stalls  = mem_blocked && (m_waited + 1 < TMO);
         e.tmo       = mem_blocked && (m_waited + 1 == TMO);
         ex_holds    = ex_busy_req || (m_pending && !ex_done && !m_result_early);
         hazard      = ex_mem_read && ex_Rd != 0 &&
                       ((id_rs1_used && id_Rs1 == ex_Rd) || (id_rs2_used && id_Rs2 == ex_Rd));
         redirect    = ex_jump_en && !mem_stalls && !ex_holds;
         if (mem_stalls)           e.hold = 3'b100;
         else if (ex_holds)        e.hold = 3'b010;
         else if (hazard && !redirect) e.hold = 3'b001;
         e.flush = redirect;
         e.jaddr = redirect ? ex_jump_addr : 32'h0;
         e.sc = m_stalls;
         e.fc = m_flushes;
         if (e.hold != 0) m_stalls = (m_stalls + 1) % (1 << CW);
         if (redirect)    m_flushes = (m_flushes + 1) % (1 << CW);
         m_waited = mem_stalls ? m_waited + 1 : 0;
         if (ex_busy_req) begin
            m_pending = 1; m_result_early = 0;
         end else if (m_pending && mem_stalls) begin
            if (ex_done) m_result_early = 1;
         end else if (m_pending && (ex_done || m_result_early)) begin
            m_pending = 0; m_result_early = 0;
         end
      end
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      sys_rst = 0; id_Rs1 = 0; id_Rs2 = 0; ex_Rd = 0;
      id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0;
      ex_busy_req = 0; ex_done = 0; mem_req = 0; mem_ack = 0;
      ex_jump_en = 0; ex_jump_addr = 0;
   endtask

   initial begin
      clr();
      sys_rst = 1;
      @(posedge clk);
      #1;
      step(); step();
      sys_rst = 0;
      step();

      // load-use hit on Rs2, then same with x0 as destination
      ex_mem_read = 1; ex_Rd = 5; id_Rs2 = 5; id_rs2_used = 1;
      step();
      clr(); step();
      ex_mem_read = 1; ex_Rd = 0; id_Rs2 = 0; id_rs2_used = 1;
      step();
      clr(); step();

      // divide: done six cycles after the request
      ex_busy_req = 1; step();
      clr(); repeat (5) step();
      ex_done = 1; step();
      clr(); step();

      // MEM ack after three wait cycles, then a full timeout
      mem_req = 1; repeat (3) step();
      mem_ack = 1; step();
      clr(); step();
      mem_req = 1; repeat (4) step();
      clr(); step();

      // EX busy overlapped by a MEM stall that swallows ex_done
      ex_busy_req = 1; step();
      clr(); step();
      mem_req = 1; step();
      ex_done = 1; step();
      ex_done = 0; step();
      mem_ack = 1; step();
      clr(); repeat (2) step();

      // jump alone, then jump held behind a MEM stall
      ex_jump_en = 1; ex_jump_addr = 32'h0000_0100; step();
      clr(); step();
      mem_req = 1; ex_jump_en = 1; ex_jump_addr = 32'h0000_0100; repeat (2) step();
      mem_ack = 1; step();
      clr(); step();

      // reset in the middle of a MEM wait
      mem_req = 1; repeat (2) step();
      sys_rst = 1; step();
      clr(); repeat (4) step();

      for (int i = 0; i < 3000; i++) begin
         sys_rst      = ($urandom_range(0, 199) == 0);
         id_Rs1       = 5'($urandom_range(0, 7));
         id_Rs2       = 5'($urandom_range(0, 7));
         ex_Rd        = 5'($urandom_range(0, 7));
         id_rs1_used  = 1'($urandom);
         id_rs2_used  = 1'($urandom);
         ex_mem_read  = 1'($urandom);
         ex_busy_req  = ($urandom_range(0, 19) == 0);
         ex_done      = ($urandom_range(0, 6) == 0);
         mem_req      = 1'($urandom);
         mem_ack      = ($urandom_range(0, 9) < 3);
         ex_jump_en   = ($urandom_range(0, 4) == 0);
         ex_jump_addr = $urandom;
         step();
      end
      clr(); step();

      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline control unit for the 5-stage core. It generates the shared 3-bit `flag_hold` code and the `flag_flush` signal consumed by every stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences four kinds of event: load-use stalls, multi-cycle EX operations, MEM bus wait states with timeout, and taken jumps/branches. It also keeps stall and flush performance counters.

Parameters:
- CNT_W, 32, width of the performance counters `stall_cnt` and `flush_cnt`.
- MEM_TIMEOUT, 255, maximum number of MEM wait cycles before a forced release; legal range 1..65535.

Ports:
- sys_clk  in  1  core clock.
- sys_rst  in  1  synchronous reset, active-high.
- id_Rs1  in  5  source register 1 of the instruction in ID.
- id_Rs2  in  5  source register 2 of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads Rs1.
- id_rs2_used  in  1  ID instruction reads Rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_Rd  in  5  destination register of the EX instruction.
- ex_busy_req  in  1  one-cycle pulse: EX started a multi-cycle op (div/rem).
- ex_done  in  1  one-cycle pulse: multi-cycle op result valid.
- mem_req  in  1  MEM stage has an active bus access.
- mem_ack  in  1  bus completes the MEM access this cycle.
- ex_jump_en  in  1  EX resolved a taken jump/branch.
- ex_jump_addr  in  32  jump target.
- flag_hold  out  3  hold code, see Behaviour.
- flag_flush  out  1  flush IF/ID and ID/EX.
- jump_en_o  out  1  redirect PC this cycle.
- jump_addr_o  out  32  PC redirect target.
- mem_timeout_o  out  1  one-cycle pulse on MEM timeout.
- stall_cnt  out  CNT_W  number of cycles with `flag_hold` != 0.
- flush_cnt  out  CNT_W  number of cycles with `flag_flush` = 1.

Behaviour:
- `flag_hold` codes (one-hot, at most one bit set):
  - 000: run.
  - 001: hold PC and IF/ID; bubble ID/EX.
  - 010: hold PC, IF/ID and ID/EX; bubble EX/MEM.
  - 100: hold PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB.
- `flag_hold`, `flag_flush`, `jump_en_o`, `jump_addr_o` and `mem_timeout_o` are combinational from current state and inputs, so they act in the same cycle. State, counters and latches are registered.
- FSM states: IDLE, EX_BUSY, MEM_WAIT. The MEM wait and the EX op are tracked independently: the `ex_pend` flag holds EX_BUSY status while in MEM_WAIT.
- Hold priority (highest first):
  1. MEM stall (100): `mem_req` & !`mem_ack` & `tmo_cnt` != MEM_TIMEOUT-1.
  2. EX busy (010): `ex_pend` & !`ex_done`, or `ex_busy_req` this cycle.
  3. Load-use (001): `ex_mem_read` & `ex_Rd` != 0 & ((`id_rs1_used` & `id_Rs1` == `ex_Rd`) | (`id_rs2_used` & `id_Rs2` == `ex_Rd`)).
  4. Otherwise 000.
- `ex_pend`:
  - Set on `ex_busy_req`.
  - Cleared on the first cycle with `ex_done` and no MEM stall.
  - `ex_done` arriving during a MEM stall sets `done_seen`. When the MEM stall ends, `ex_pend` and `done_seen` clear and the hold code drops to 000 in that cycle.
- MEM_WAIT:
  - Entered on `mem_req` & !`mem_ack`.
  - `tmo_cnt` increments each cycle in MEM_WAIT and resets to 0 on leaving.
  - If no `mem_ack` arrives by wait cycle MEM_TIMEOUT: `mem_timeout_o` = 1 for that cycle, hold is released (treated as ack), and state returns to IDLE.
  - `mem_ack` in the same cycle as `mem_req` means no stall.
- Jump handling:
  - `flag_flush` = `jump_en_o` = `ex_jump_en` & (`flag_hold` == 000 or 001).
  - When `flag_hold`[2] or `flag_hold`[1] is set, flush is suppressed. The held EX instruction re-presents `ex_jump_en` when released.
  - `jump_addr_o` = `ex_jump_addr` when `jump_en_o`, else 0.
  - A flush overrides load-use: when flushing, `flag_hold` is forced to 000 because the ID instruction is discarded.
- Counters: increment by 1 per qualifying cycle and wrap at 2^CNT_W.
- Reset (`sys_rst` sampled high at the edge):
  - State → IDLE; `ex_pend`, `done_seen`, `tmo_cnt`, `stall_cnt`, `flush_cnt` → 0.
  - While `sys_rst` = 1, all outputs are forced to 0.
  - Reset during MEM_WAIT or EX_BUSY abandons the operation with no timeout pulse.

Test Plan:
1. Load-use: `ex_mem_read` = 1, `ex_Rd` = 5, `id_Rs2` = 5, `id_rs2_used` = 1 → `flag_hold` = 001 for exactly one cycle. Repeat with `ex_Rd` = 0 → `flag_hold` = 000.
2. Divide: `ex_busy_req` pulse, `ex_done` 6 cycles later → `flag_hold` = 010 for 6 cycles, 000 on the `ex_done` cycle; `stall_cnt` = 6.
3. MEM wait: `mem_req` = 1, `mem_ack` after 3 cycles → `flag_hold` = 100 for 3 cycles. With MEM_TIMEOUT = 4 and no ack → 100 for 3 cycles, then `mem_timeout_o` = 1 and hold 000 on cycle 4.
4. Overlap: EX_BUSY active, MEM stall starts, `ex_done` arrives during the stall → hold 100 throughout the stall, then 000 on the release cycle, with no 010 afterwards.
5. Jump: `ex_jump_en` = 1, `ex_jump_addr` = 0x0000_0100 with no stall → `flag_flush` = 1, `jump_addr_o` = 0x100, `flush_cnt` = 1. Same jump during a MEM stall → no flush until the stall releases, then exactly one flush.
6. Reset: assert `sys_rst` mid MEM_WAIT → outputs 0, counters 0, and no `mem_timeout_o` after deassertion.
